mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control sequencer for the RV32I subset core (lw, sw, add/sub/and/or/slt, addi/andi/ori/slti, beq, jal). It drives a multicycle variant of the datapath, in which the ALU, adder and memory port are shared across cycles rather than duplicated. The block steps each instruction through a Moore FSM, decodes ALU and immediate controls, and gates PC, IR, register-file and memory writes.

## Interface
- No parameters. All encodings are fixed constants in `mc_defs.vh`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: Instr[6:0] from the instruction register.
- `funct3` in 3: Instr[14:12].
- `funct7b5` in 1: Instr[30].
- `Zero` in 1: ALU zero flag, same cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register and OldPC enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = A (rs1).
- `ALUSrcB` out 2: ALU B select. 00 = WriteData (rs2), 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` out 3: ALU operation. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `State` out 4: current state, for debug and verification.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Per-state outputs. Any output not listed for a state is 0.
  - FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: SrcA=01, SrcB=01, ALUOp=00. This precomputes the branch target.
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECR: SrcA=10, SrcB=00, ALUOp=10.
  - EXECI: SrcA=10, SrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- `PCWrite` = PCUpdate | (Branch & Zero). This is the only output that depends on `Zero`.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 (R-type) → EXECR.
    - 0010011 (I-type ALU) → EXECI.
    - 1101111 (jal) → JAL.
    - 1100011 (beq) → BEQ.
    - any other opcode → FETCH.
  - MEMADR → MEMREAD when op=lw, else → MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECR and EXECI → ALUWB → FETCH.
  - JAL → ALUWB.
  - BEQ → FETCH.
- ALU decode, from internal ALUOp:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, by `funct3`:
    - 000 → sub if op[5]&funct7b5, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - other → add.
- ImmSrc is decoded combinationally from `op`: lw / I-type / R-type → 00, sw → 01, beq → 10, jal → 11, other → 00.
- Illegal opcode: DECODE returns to FETCH. No RegWrite or MemWrite is issued; the PC has already advanced by 4.

## Timing
- Cycles per instruction, including FETCH:
  - lw 5.
  - sw, R-type, I-type and jal 4.
  - beq 3.
  - illegal opcode 2.
- Outputs are combinational from the state register (plus `op`/`funct` and `Zero` where noted). They are valid in the same cycle the state is entered, with no output register.
- Reset:
  - While `reset`=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - All other outputs take their FETCH values while `reset`=1.
  - On the edge with `reset`=1 the state becomes FETCH.
  - A reset asserted mid-instruction aborts it; no partial write follows.
- `State` reads 0 (FETCH) out of reset.
- `op` and `funct` come from the IR and are stable from DECODE onward. The IR only changes in FETCH.

## Structure
- `mc_defs.vh`, included by this block and the multicycle datapath, holds:
  - 4-bit state codes (FETCH=0 … JAL=10).
  - Opcode constants.
  - ALUOp, ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- Sub-module `alu_decoder`, combinational: (ALUOp, funct3, op5, funct7b5) → ALUControl. It is reusable by the single-cycle control unit.
- The top level holds the state register, next-state logic, the output ROM-style case statement and the ImmSrc decode.

## Test plan
- Reset held for 2 cycles, then released with op=0110011 (add): State sequence 0→1→6→8→0. RegWrite=1 only in ALUWB. ALUControl=000 in EXECR.
- op=0000011 (lw): State sequence 0,1,2,3,4,0. AdrSrc=1 in MEMREAD. ResultSrc=01 with RegWrite=1 in MEMWB. ImmSrc=00.
- op=0100011 (sw): MemWrite=1 for exactly one cycle, in MEMWRITE. ImmSrc=01. RegWrite never asserted.
- op=1100011 (beq):
  - Zero=1 in BEQ → PCWrite=1 and ALUControl=001.
  - Zero=0 → PCWrite=0.
  - Next state is FETCH in both cases.
- op=0110011, funct3=000, funct7b5=1 → ALUControl=001. op=0010011, funct3=000, funct7b5=1 → ALUControl=000. funct3=010 → 101.
- Special cases:
  - op=1111111 → DECODE→FETCH with no write enable asserted.
  - reset asserted during MEMWRITE → MemWrite=0 that cycle, State=0 on the next cycle.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: state codes, opcodes and control encodings shared by the
// multicycle control unit and its datapath.
package mc_controller_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: maps ALUOp and instruction function fields to an ALU operation;
// shared with the single-cycle control unit.
module alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);
    logic [2:0] funct_ctrl;

    always_comb begin
        case (funct3)
            3'b000:  funct_ctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctrl = ALU_SLT;
            3'b110:  funct_ctrl = ALU_OR;
            3'b111:  funct_ctrl = ALU_AND;
            default: funct_ctrl = ALU_ADD;
        endcase
    end

    assign alu_control = alu_op == ALUOP_SUB ? ALU_SUB : alu_op == ALUOP_FUNCT ? funct_ctrl : ALU_ADD;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing RV32I instructions through the shared
// multicycle datapath, with ALU/immediate decode and gated write enables.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);
    logic [3:0] state, next_state, cur;
    ctrl_t c;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        case (state)
            S_FETCH:   next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: next_state = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // Reset presents the FETCH control word so the datapath sees a quiescent fetch.
    assign cur = reset ? S_FETCH : state;

    always_comb begin
        c = '0;
        case (cur)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_REG;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op     (c.alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alu_control(ALUControl)
    );

    assign PCWrite   = ~reset & (c.pc_update | (c.branch & Zero));
    assign IRWrite   = ~reset & c.ir_write;
    assign RegWrite  = ~reset & c.reg_write;
    assign MemWrite  = ~reset & c.mem_write;
    assign AdrSrc    = c.adr_src;
    assign ResultSrc = c.result_src;
    assign ALUSrcA   = c.alu_src_a;
    assign ALUSrcB   = c.alu_src_b;
    assign ImmSrc    = imm_src(op);
    assign State     = cur;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: instruction-level reference model feeds a per-cycle
// expectation queue; a negedge monitor compares the full control word.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic [19:0] exp_q[$];
    logic [19:0] act, e;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
    );

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, State};

    // Expected control word for one cycle spent in state st.
    function automatic logic [19:0] model(input int st, input logic rst, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic z);
        logic pcu = 0, br = 0, adr = 0, mw = 0, irw = 0, rw = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0, imm;
        logic [2:0] ac;
        logic [3:0] sv;
        sv = rst ? 4'd0 : 4'(st);
        case (sv)
            0: begin pcu = 1; irw = 1; sb = 2; rs = 2; end
            1: begin sa = 1; sb = 1; end
            2: begin sa = 2; sb = 1; end
            3: adr = 1;
            4: begin rs = 1; rw = 1; end
            5: begin adr = 1; mw = 1; end
            6: begin sa = 2; aop = 2; end
            7: begin sa = 2; sb = 1; aop = 2; end
            8: rw = 1;
            9: begin sa = 2; aop = 1; br = 1; end
            10: begin sa = 1; sb = 2; pcu = 1; end
            default: ;
        endcase
        ac = aop == 0 ? 3'd0 : aop == 1 ? 3'd1 :
             f3 == 3'd0 ? ((o[5] & f7) ? 3'd1 : 3'd0) :
             f3 == 3'd2 ? 3'd5 : f3 == 3'd6 ? 3'd3 : f3 == 3'd7 ? 3'd2 : 3'd0;
        case (o)
            7'b0100011: imm = 2'd1;
            7'b1100011: imm = 2'd2;
            7'b1101111: imm = 2'd3;
            default:    imm = 2'd0;
        endcase
        return {~rst & (pcu | (br & z)), adr, ~rst & mw, ~rst & irw, ~rst & rw, rs, sa, sb, imm, ac, sv};
    endfunction

    task automatic step(input logic [19:0] x);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; abort_at >= 0 pulses reset on that cycle of it.
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int abort_at);
        int p[5];
        int n;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        case (o)
            7'b0000011: begin p = '{0, 1, 2, 3, 4}; n = 5; end
            7'b0100011: begin p = '{0, 1, 2, 5, 0}; n = 4; end
            7'b0110011: begin p = '{0, 1, 6, 8, 0}; n = 4; end
            7'b0010011: begin p = '{0, 1, 7, 8, 0}; n = 4; end
            7'b1101111: begin p = '{0, 1, 10, 8, 0}; n = 4; end
            7'b1100011: begin p = '{0, 1, 9, 0, 0}; n = 3; end
            default:    begin p = '{0, 1, 0, 0, 0}; n = 2; end
        endcase
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                step(model(p[i], 1'b1, o, f3, f7, z));
                reset = 1'b0;
                break;
            end
            step(model(p[i], 1'b0, o, f3, f7, z));
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL ctrl @%0t: got %05h (State=%0d) expected %05h (State=%0d)",
                         $time, act, act[3:0], e, e[3:0]);
            end
        end
    end

    initial begin
        logic [6:0] ops[6];
        logic [6:0] o;
        int k;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk);
        #1;
        step(model(0, 1'b1, op, funct3, funct7b5, Zero));
        step(model(0, 1'b1, op, funct3, funct7b5, Zero));
        reset = 1'b0;
        run(7'b0110011, 3'b000, 1'b0, 1'b0, -1);
        run(7'b0000011, 3'b010, 1'b0, 1'b1, -1);
        run(7'b0100011, 3'b010, 1'b1, 1'b1, -1);
        run(7'b1100011, 3'b000, 1'b0, 1'b1, -1);
        run(7'b1100011, 3'b000, 1'b0, 1'b0, -1);
        run(7'b0110011, 3'b000, 1'b1, 1'b0, -1);
        run(7'b0010011, 3'b000, 1'b1, 1'b0, -1);
        run(7'b0110011, 3'b010, 1'b0, 1'b0, -1);
        run(7'b0010011, 3'b110, 1'b0, 1'b0, -1);
        run(7'b0110011, 3'b111, 1'b1, 1'b0, -1);
        run(7'b1101111, 3'b101, 1'b1, 1'b1, -1);
        run(7'b1111111, 3'b000, 1'b0, 1'b1, -1);
        run(7'b0100011, 3'b010, 1'b0, 1'b0, 3);
        run(7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 7);
            o = k < 6 ? ops[k] : 7'($urandom);
            run(o, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 4)) : -1);
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
